// File: rtl/dense_argmax.sv
// Sequential arg-max over NUM_CLASS signed class scores: one score per cycle,
// reporting the winning index, its score and the margin over the runner-up.
module dense_argmax #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CLASS  = 7,
  parameter int CLS_W      = 3
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [DATA_WIDTH*NUM_CLASS-1:0] data_i,
  input  logic                            valid_i,
  output logic [CLS_W-1:0]                class_o,
  output logic [DATA_WIDTH-1:0]           score_o,
  output logic [DATA_WIDTH-1:0]           margin_o,
  output logic                            valid_o,
  output logic                            busy_o,
  output logic                            overrun_o
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [CLS_W-1:0]      LAST_IDX  = CLS_W'(NUM_CLASS - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                          state;
  logic [DATA_WIDTH*NUM_CLASS-1:0] pending;
  logic signed [DATA_WIDTH-1:0]    best;
  logic signed [DATA_WIDTH-1:0]    second;
  logic [CLS_W-1:0]                best_idx;
  logic [CLS_W-1:0]                idx;

  logic signed [DATA_WIDTH-1:0]    cur;
  logic signed [DATA_WIDTH-1:0]    next_best;
  logic signed [DATA_WIDTH-1:0]    next_second;
  logic [CLS_W-1:0]                next_idx;
  logic [DATA_WIDTH-1:0]           next_margin;

  // The unscanned scores are kept in a shift register, so the current one is
  // always the bottom slice and no variable index is needed.
  assign cur = pending[DATA_WIDTH-1:0];

  // Strict greater-than keeps ties on the lowest index; an equal score still
  // becomes the runner-up, which drives the margin to zero.
  always_comb begin
    next_best   = best;
    next_second = second;
    next_idx    = best_idx;
    if (cur > best) begin
      next_second = best;
      next_best   = cur;
      next_idx    = idx;
    end else if (cur > second) begin
      next_second = cur;
    end
  end

  // best >= second always holds, so the wide difference is non-negative and
  // its low bits equal this modular subtract.
  assign next_margin = next_best - next_second;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      pending   <= '0;
      best      <= '0;
      second    <= '0;
      best_idx  <= '0;
      idx       <= '0;
      class_o   <= '0;
      score_o   <= '0;
      margin_o  <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            pending  <= data_i >> DATA_WIDTH;
            best     <= data_i[DATA_WIDTH-1:0];
            second   <= MOST_NEG;
            best_idx <= '0;
            idx      <= CLS_W'(1);
            busy_o   <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (valid_i) begin
            overrun_o <= 1'b1;
          end
          best     <= next_best;
          second   <= next_second;
          best_idx <= next_idx;
          pending  <= pending >> DATA_WIDTH;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            class_o  <= next_idx;
            score_o  <= next_best;
            margin_o <= next_margin;
            valid_o  <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
